// File: rtl/rf_wb_arbiter_if.sv
// Register-file writeback bus: pipeline/divider/load writeback sources, long-latency
// issue with scoreboard, operand hazard checks and the registered RF write port.
interface rf_wb_arbiter_if;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_idx;
    logic [31:0] pipe_wb_data;

    logic        div_valid;
    logic [4:0]  div_idx;
    logic [31:0] div_data;
    logic        div_ready;

    logic        mem_valid;
    logic [4:0]  mem_idx;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic        issue_valid;
    logic [4:0]  issue_idx;
    logic        issue_ready;

    logic [4:0]  chk_rj_idx;
    logic [4:0]  chk_rk_idx;
    logic        rj_hazard;
    logic        rk_hazard;

    logic        rf_we;
    logic [4:0]  rf_idx;
    logic [31:0] rf_data;
    logic [31:0] pending;

    // Requesting side: the pipeline, divider, load unit and issue stage.
    modport master (
        output pipe_wb_valid, pipe_wb_idx, pipe_wb_data,
        output div_valid, div_idx, div_data,
        input  div_ready,
        output mem_valid, mem_idx, mem_data,
        input  mem_ready,
        output issue_valid, issue_idx,
        input  issue_ready,
        output chk_rj_idx, chk_rk_idx,
        input  rj_hazard, rk_hazard,
        input  rf_we, rf_idx, rf_data, pending
    );

    // Arbiter side.
    modport slave (
        input  pipe_wb_valid, pipe_wb_idx, pipe_wb_data,
        input  div_valid, div_idx, div_data,
        output div_ready,
        input  mem_valid, mem_idx, mem_data,
        output mem_ready,
        input  issue_valid, issue_idx,
        output issue_ready,
        input  chk_rj_idx, chk_rk_idx,
        output rj_hazard, rk_hazard,
        output rf_we, rf_idx, rf_data, pending
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Single-port register-file writeback arbiter: pipeline has priority, divider and load
// return share round-robin; a pending-bit scoreboard tracks outstanding long-latency results.
module rf_wb_arbiter #(
    parameter bit WAW_STALL = 1'b1
) (
    input logic            clk,
    input logic            rstn,
    rf_wb_arbiter_if.slave bus
);
    typedef enum logic {SRC_DIV = 1'b0, SRC_MEM = 1'b1} src_e;

    src_e        last_grant;
    logic        div_gnt;
    logic        mem_gnt;
    logic        any_gnt;
    logic        issue_ok;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        rf_we_q;
    logic [4:0]  rf_idx_q;
    logic [31:0] rf_data_q;
    logic [31:0] pending_q;

    // Readies are gated by rstn so no handshake can complete while reset is held.
    always_comb begin
        div_gnt = rstn && !bus.pipe_wb_valid && bus.div_valid &&
                  (!bus.mem_valid || last_grant == SRC_MEM);
        mem_gnt = rstn && !bus.pipe_wb_valid && bus.mem_valid &&
                  (!bus.div_valid || last_grant == SRC_DIV);
        issue_ok = rstn && ((WAW_STALL == 1'b0) || !pending_q[bus.issue_idx] ||
                            (bus.issue_idx == 5'd0));
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_idx   = bus.pipe_wb_idx;
        wr_data  = bus.pipe_wb_data;
        set_mask = '0;
        clr_mask = '0;
        if (div_gnt) begin
            wr_idx  = bus.div_idx;
            wr_data = bus.div_data;
        end else if (mem_gnt) begin
            wr_idx  = bus.mem_idx;
            wr_data = bus.mem_data;
        end
        any_gnt = bus.pipe_wb_valid || div_gnt || mem_gnt;
        if (div_gnt || mem_gnt)
            clr_mask[wr_idx] = 1'b1;
        if (bus.issue_valid && issue_ok && bus.issue_idx != 5'd0)
            set_mask[bus.issue_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we_q    <= 1'b0;
            rf_idx_q   <= 5'd0;
            rf_data_q  <= 32'd0;
            pending_q  <= 32'd0;
            last_grant <= SRC_MEM;
        end else begin
            rf_we_q <= any_gnt && (wr_idx != 5'd0);
            if (any_gnt) begin
                rf_idx_q  <= wr_idx;
                rf_data_q <= wr_data;
            end
            // Set wins over a same-cycle clear; register 0 never becomes pending.
            pending_q <= ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
            if (div_gnt)
                last_grant <= SRC_DIV;
            else if (mem_gnt)
                last_grant <= SRC_MEM;
        end
    end

    function automatic logic hazard(input logic [4:0] idx);
        return (idx != 5'd0) && (pending_q[idx] || (rf_we_q && rf_idx_q == idx));
    endfunction

    assign bus.div_ready   = div_gnt;
    assign bus.mem_ready   = mem_gnt;
    assign bus.issue_ready = issue_ok;
    assign bus.rj_hazard   = hazard(bus.chk_rj_idx);
    assign bus.rk_hazard   = hazard(bus.chk_rk_idx);
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_idx      = rf_idx_q;
    assign bus.rf_data     = rf_data_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: table-driven arbitration vectors plus
// hand-written scoreboard, index-0, reset and hazard sequences.
module tb_rf_wb_arbiter;
    logic clk;
    logic rstn;
    int   n_cmp  = 0;
    int   n_fail = 0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.WAW_STALL(1'b1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        pv; logic [4:0] pi; logic [31:0] pd;
        logic        dv; logic [4:0] di; logic [31:0] dd;
        logic        mv; logic [4:0] mi; logic [31:0] md;
        logic        exp_dr;
        logic        exp_mr;
        logic        exp_we;
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.pipe_wb_valid = 1'b0; bus.pipe_wb_idx = '0; bus.pipe_wb_data = '0;
        bus.div_valid     = 1'b0; bus.div_idx     = '0; bus.div_data     = '0;
        bus.mem_valid     = 1'b0; bus.mem_idx     = '0; bus.mem_data     = '0;
        bus.issue_valid   = 1'b0; bus.issue_idx   = '0;
    endtask

    // Push the expected RF write for this cycle, clock it in, and compare one cycle later.
    task automatic tick(input logic we, input logic [4:0] idx, input logic [31:0] data);
        wr_t e;
        exp_q.push_back('{we, idx, data});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("rf_we", {31'd0, bus.rf_we}, {31'd0, e.we});
        if (e.we) begin
            check("rf_idx", {27'd0, bus.rf_idx}, {27'd0, e.idx});
            check("rf_data", bus.rf_data, e.data);
        end
    endtask

    initial begin
        // Vectors start right after reset: last_grant points at mem, so div wins the first conflict.
        vecs[0] = '{1, 5'd5, 32'hA,  1, 5'd6, 32'h1111_0006, 1, 5'd7, 32'h2222_0007, 0, 0, 1, 5'd5, 32'hA};
        vecs[1] = '{0, 5'd0, 32'h0,  1, 5'd6, 32'h1111_0006, 1, 5'd7, 32'h2222_0007, 1, 0, 1, 5'd6, 32'h1111_0006};
        vecs[2] = '{0, 5'd0, 32'h0,  1, 5'd6, 32'h1111_0006, 1, 5'd7, 32'h2222_0007, 0, 1, 1, 5'd7, 32'h2222_0007};
        vecs[3] = '{0, 5'd0, 32'h0,  1, 5'd6, 32'h3333_0006, 1, 5'd7, 32'h4444_0007, 1, 0, 1, 5'd6, 32'h3333_0006};
        vecs[4] = '{0, 5'd0, 32'h0,  1, 5'd6, 32'h3333_0006, 1, 5'd7, 32'h4444_0007, 0, 1, 1, 5'd7, 32'h4444_0007};
        vecs[5] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         1, 5'd0, 32'hFFFF_FFFF, 0, 1, 0, 5'd0, 32'h0};
        vecs[6] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 0, 0, 5'd0, 32'h0};
        vecs[7] = '{0, 5'd0, 32'h0,  1, 5'd3, 32'hDEAD_BEEF, 0, 5'd0, 32'h0,         1, 0, 1, 5'd3, 32'hDEAD_BEEF};
        vecs[8] = '{0, 5'd0, 32'h0,  1, 5'd4, 32'h5,         1, 5'd13, 32'h0123_4567, 0, 1, 1, 5'd13, 32'h0123_4567};
        vecs[9] = '{1, 5'd0, 32'h5,  0, 5'd0, 32'h0,         1, 5'd2, 32'h77,        0, 0, 0, 5'd0, 32'h0};

        // Reset with requests asserted: nothing may handshake.
        rstn = 1'b0;
        idle();
        bus.chk_rj_idx = '0;
        bus.chk_rk_idx = '0;
        bus.div_valid = 1'b1; bus.mem_valid = 1'b1; bus.issue_valid = 1'b1; bus.issue_idx = 5'd4;
        #3;
        check("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
        check("rst_pending", bus.pending, 32'd0);
        check("rst_div_ready", {31'd0, bus.div_ready}, 32'd0);
        check("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst_issue_ready", {31'd0, bus.issue_ready}, 32'd0);
        @(negedge clk);
        idle();
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            idle();
            bus.pipe_wb_valid = vecs[i].pv; bus.pipe_wb_idx = vecs[i].pi; bus.pipe_wb_data = vecs[i].pd;
            bus.div_valid     = vecs[i].dv; bus.div_idx     = vecs[i].di; bus.div_data     = vecs[i].dd;
            bus.mem_valid     = vecs[i].mv; bus.mem_idx     = vecs[i].mi; bus.mem_data     = vecs[i].md;
            #1;
            check($sformatf("vec%0d_div_ready", i), {31'd0, bus.div_ready}, {31'd0, vecs[i].exp_dr});
            check($sformatf("vec%0d_mem_ready", i), {31'd0, bus.mem_ready}, {31'd0, vecs[i].exp_mr});
            tick(vecs[i].exp_we, vecs[i].exp_idx, vecs[i].exp_data);
        end

        // Hazard on a pending load result, through grant and RF write, then clear.
        idle();
        bus.issue_valid = 1'b1; bus.issue_idx = 5'd9;
        #1;
        check("issue_ready_9", {31'd0, bus.issue_ready}, 32'd1);
        tick(1'b0, 5'd0, 32'd0);
        idle();
        bus.chk_rj_idx = 5'd9;
        bus.chk_rk_idx = 5'd9;
        #1;
        check("pending_9", bus.pending, 32'h0000_0200);
        check("rj_hazard_pending", {31'd0, bus.rj_hazard}, 32'd1);
        check("rk_hazard_pending", {31'd0, bus.rk_hazard}, 32'd1);
        bus.mem_valid = 1'b1; bus.mem_idx = 5'd9; bus.mem_data = 32'hCAFE_0009;
        #1;
        check("mem_ready_9", {31'd0, bus.mem_ready}, 32'd1);
        check("rj_hazard_grant", {31'd0, bus.rj_hazard}, 32'd1);
        tick(1'b1, 5'd9, 32'hCAFE_0009);
        idle();
        #1;
        check("pending_9_cleared", bus.pending, 32'd0);
        check("rj_hazard_rf_we", {31'd0, bus.rj_hazard}, 32'd1);
        tick(1'b0, 5'd0, 32'd0);
        #1;
        check("rj_hazard_done", {31'd0, bus.rj_hazard}, 32'd0);
        check("rk_hazard_done", {31'd0, bus.rk_hazard}, 32'd0);
        bus.chk_rj_idx = 5'd0;
        bus.chk_rk_idx = 5'd0;

        // Same-cycle set and clear of idx 12, then WAW stall and index-0 handling.
        idle();
        bus.div_valid = 1'b1; bus.div_idx = 5'd12; bus.div_data = 32'h0000_000C;
        bus.issue_valid = 1'b1; bus.issue_idx = 5'd12;
        #1;
        check("div_ready_12", {31'd0, bus.div_ready}, 32'd1);
        check("issue_ready_12_free", {31'd0, bus.issue_ready}, 32'd1);
        tick(1'b1, 5'd12, 32'h0000_000C);
        idle();
        #1;
        check("pending_12_set_wins", bus.pending, 32'h0000_1000);
        bus.issue_valid = 1'b1; bus.issue_idx = 5'd12;
        #1;
        check("issue_ready_12_stall", {31'd0, bus.issue_ready}, 32'd0);
        bus.issue_idx = 5'd0;
        #1;
        check("issue_ready_idx0", {31'd0, bus.issue_ready}, 32'd1);
        idle();
        bus.mem_valid = 1'b1; bus.mem_idx = 5'd0; bus.mem_data = 32'hFFFF_FFFF;
        #1;
        check("mem_ready_idx0", {31'd0, bus.mem_ready}, 32'd1);
        tick(1'b0, 5'd0, 32'd0);
        idle();
        #1;
        check("pending_after_idx0", bus.pending, 32'h0000_1000);
        bus.div_valid = 1'b1; bus.div_idx = 5'd12; bus.div_data = 32'h1;
        tick(1'b1, 5'd12, 32'h1);
        idle();
        #1;
        check("pending_12_cleared", bus.pending, 32'd0);

        // Build pending=0x0F00 with an RF write in flight, then reset mid-cycle.
        for (int i = 8; i < 12; i++) begin
            idle();
            bus.issue_valid = 1'b1; bus.issue_idx = 5'(i);
            if (i == 11) begin
                bus.div_valid = 1'b1; bus.div_idx = 5'd3; bus.div_data = 32'h33;
            end
            tick(i == 11, 5'd3, 32'h33);
        end
        idle();
        #1;
        check("pending_pre_reset", bus.pending, 32'h0000_0F00);
        check("rf_we_pre_reset", {31'd0, bus.rf_we}, 32'd1);
        bus.div_valid = 1'b1; bus.div_idx = 5'd1; bus.div_data = 32'h99;
        bus.mem_valid = 1'b1; bus.mem_idx = 5'd2; bus.mem_data = 32'h98;
        bus.issue_valid = 1'b1; bus.issue_idx = 5'd20;
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_pending", bus.pending, 32'd0);
        check("midrst_rf_we", {31'd0, bus.rf_we}, 32'd0);
        check("midrst_div_ready", {31'd0, bus.div_ready}, 32'd0);
        check("midrst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("midrst_issue_ready", {31'd0, bus.issue_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_rf_we_held", {31'd0, bus.rf_we}, 32'd0);
        @(negedge clk);
        idle();
        rstn = 1'b1;
        tick(1'b0, 5'd0, 32'd0);

        // Round-robin pointer is back at mem: div wins, then mem.
        idle();
        bus.div_valid = 1'b1; bus.div_idx = 5'd1; bus.div_data = 32'hA1;
        bus.mem_valid = 1'b1; bus.mem_idx = 5'd2; bus.mem_data = 32'hB2;
        #1;
        check("postrst_div_ready", {31'd0, bus.div_ready}, 32'd1);
        check("postrst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        tick(1'b1, 5'd1, 32'hA1);
        #1;
        check("postrst_mem_turn", {31'd0, bus.mem_ready}, 32'd1);
        tick(1'b1, 5'd2, 32'hB2);
        idle();
        tick(1'b0, 5'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
